rr_cfg_axil_regfile: RTL and testbench
======================================

// Module: rr_cfg_axil_regfile
// PURPOSE
//  AXI-Lite responder terminating the rr configuration bus (M01, high 1MB of BAR1).
//  Holds N_RW writable control registers and exposes N_RO read-only status words.
//  Also exposes two transaction counters. Drives per-register write pulses into the record/replay logic.
// PARAMETERS
//  ADDR_WIDTH     32     AXI-Lite address width (byte address)
//  N_RW           8      number of 32-bit RW control registers
//  N_RO           8      number of 32-bit RO status words
//  CFG_RESET_VAL  32'h0  reset value of every RW register
// PORTS
//  clk           in   1            clock; all logic single-domain
//  rst           in   1            asynchronous, active-high reset
//  awaddr        in   ADDR_WIDTH   write address
//  awvalid/awready  in/out  1      AW handshake
//  wdata         in   32           write data
//  wstrb         in   4            byte enables
//  wvalid/wready in/out  1         W handshake
//  bresp         out  2            2'b00 OKAY, 2'b10 SLVERR
//  bvalid/bready out/in  1         B handshake
//  araddr        in   ADDR_WIDTH   read address
//  arvalid/arready  in/out  1      AR handshake
//  rdata         out  32           read data
//  rresp         out  2            2'b00 OKAY, 2'b10 SLVERR
//  rvalid/rready out/in  1         R handshake
//  cfg_regs      out  N_RW*32      RW register contents; reg i at [32*i +: 32]
//  cfg_wr_pulse  out  N_RW         1-cycle strobe per committed write to reg i
//  status_in     in   N_RO*32      RO status words; word j at [32*j +: 32]
// BEHAVIOUR
//  Map: word index k = addr[ADDR_WIDTH-1:2]; addr[1:0] ignored.
//    k < N_RW: RW reg k. N_RW <= k < N_RW+N_RO: status word k-N_RW.
//    k = N_RW+N_RO: WR_CNT. k = N_RW+N_RO+1: RD_CNT. Higher k: unmapped, no aliasing.
//  Reset (rst=1, async): bvalid=rvalid=0; awready=wready=arready=0; bresp=rresp=0; rdata=0.
//    cfg_regs=CFG_RESET_VAL; cfg_wr_pulse=0; counters=0.
//    Any captured-but-uncommitted AW/W is discarded; an outstanding B/R is dropped.
//    Readies are 1 from the first clk edge after rst deasserts.
//  Write path: AW and W are accepted independently, in either order, and held in aw_hold/w_hold.
//    awready = !aw_hold && !bvalid; wready = !w_hold && !bvalid.
//    Commit occurs on the edge at which the later of the two handshakes completes; both may complete in the same cycle.
//    At commit: reg written with byte merge per wstrb; bvalid=1 the next cycle; cfg_wr_pulse[i]=1 for that one cycle only.
//    cfg_regs shows the new value in the same cycle bvalid rises.
//    wstrb=0 -> OKAY, data unchanged, pulse still fires.
//    bvalid holds until bready. Holds clear at commit; no new AW/W is accepted until the B handshake.
//    Write to a status word or unmapped address -> SLVERR, no state change, no pulse.
//    Write to WR_CNT/RD_CNT -> OKAY and clears that counter, ignoring data/wstrb.
//  Read path: arready = !rvalid. On AR handshake, rdata/rresp are registered; rvalid=1 next cycle.
//    rvalid holds (rdata stable) until rready. status_in is sampled at the AR handshake edge.
//    Unmapped address -> SLVERR, rdata=0.
//  Counters: 32-bit, wrap 32'hFFFFFFFF -> 0.
//    WR_CNT +1 per OKAY write commit, excluding writes that clear a counter.
//    RD_CNT +1 per OKAY AR handshake. Reading RD_CNT returns the pre-increment value.
//    Simultaneous RD_CNT clear and OKAY read accept -> RD_CNT=1 (increment applied after clear).
//  Read and write paths are fully independent.
//    A read of reg i in the cycle of the write commit to reg i returns the old value.
// TESTING
//  1. Reset release; read reg0 -> rdata=CFG_RESET_VAL, OKAY, rvalid 1 cycle after AR handshake; RD_CNT then reads 1.
//  2. AW@0x4, W=32'hA5A5_1234 with wstrb=4'b0101, same cycle, reg1 previously 0.
//     -> reg1=32'h00A5_0034; cfg_wr_pulse[1] for 1 cycle; bvalid next cycle, OKAY.
//  3. W at cycle 0, AW at cycle 3, bready low 5 cycles.
//     -> commit at cycle 3; bvalid held, awready=wready=0 until B handshake; WR_CNT=1.
//  4. Write to status word (k=N_RW) and to k=N_RW+N_RO+2.
//     -> SLVERR on both, no pulse, cfg_regs unchanged; read of k=N_RW+N_RO+2 -> SLVERR, rdata=0.
//  5. Preload RD_CNT=32'hFFFFFFFF and accept one read -> RD_CNT=0.
//     Write RD_CNT in the same cycle as an OKAY AR accept -> RD_CNT=1.
//  6. Assert rst while W is held and rvalid=1 -> bvalid/rvalid=0 immediately; cfg_regs reset.
//     After release, a fresh AW alone produces no B response.

Source files
------------

// File: rtl/rr_cfg_axil_regfile_if.sv
// AXI-Lite channel bundle for the rr configuration bus.
// The master side drives addresses, data and response-readies; the slave side answers.
interface rr_cfg_axil_regfile_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/rr_cfg_axil_regfile.sv
// AXI-Lite register file for the rr configuration bus: RW control registers,
// RO status words, and write/read transaction counters with per-register write strobes.
module rr_cfg_axil_regfile #(
    parameter int          ADDR_WIDTH    = 32,
    parameter int          N_RW          = 8,
    parameter int          N_RO          = 8,
    parameter logic [31:0] CFG_RESET_VAL = 32'h0
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_cfg_axil_regfile_if.slave axil,
    output logic [N_RW*32-1:0]   cfg_regs,
    output logic [N_RW-1:0]      cfg_wr_pulse,
    input  logic [N_RO*32-1:0]   status_in
);
    localparam int            KW          = ADDR_WIDTH - 2;
    localparam logic [KW-1:0] K_RO        = KW'(N_RW);
    localparam logic [KW-1:0] K_WR_CNT    = KW'(N_RW + N_RO);
    localparam logic [KW-1:0] K_RD_CNT    = KW'(N_RW + N_RO + 1);
    localparam logic [1:0]    RESP_OKAY   = 2'b00;
    localparam logic [1:0]    RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        REGION_RW,
        REGION_RO,
        REGION_WR_CNT,
        REGION_RD_CNT,
        REGION_NONE
    } region_e;

    function automatic region_e decode(input logic [KW-1:0] k);
        if (k < K_RO)          return REGION_RW;
        else if (k < K_WR_CNT) return REGION_RO;
        else if (k == K_WR_CNT) return REGION_WR_CNT;
        else if (k == K_RD_CNT) return REGION_RD_CNT;
        else                   return REGION_NONE;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_val,
                                          input logic [31:0] data,
                                          input logic [3:0]  strb);
        logic [31:0] result;
        result = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) result[8*b +: 8] = data[8*b +: 8];
        end
        return result;
    endfunction

    logic          ready_en;
    logic          aw_hold;
    logic [KW-1:0] aw_k_q;
    logic          w_hold;
    logic [31:0]   w_data_q;
    logic [3:0]    w_strb_q;
    logic          bvalid_q;
    logic [1:0]    bresp_q;
    logic          rvalid_q;
    logic [31:0]   rdata_q;
    logic [1:0]    rresp_q;
    logic [31:0]   wr_cnt;
    logic [31:0]   rd_cnt;
    logic [31:0]   rd_cnt_next;
    logic [31:0]   regs [N_RW];
    logic [N_RW-1:0] pulse_q;

    logic          aw_hs, w_hs, ar_hs, commit, rd_ok;
    logic [KW-1:0] w_k, r_k;
    logic [31:0]   cm_data, rd_word;
    logic [3:0]    cm_strb;
    region_e       w_region, r_region;
    logic          addr_lsb_unused;

    assign axil.awready = ready_en && !aw_hold && !bvalid_q;
    assign axil.wready  = ready_en && !w_hold && !bvalid_q;
    assign axil.arready = ready_en && !rvalid_q;
    assign axil.bvalid  = bvalid_q;
    assign axil.bresp   = bresp_q;
    assign axil.rvalid  = rvalid_q;
    assign axil.rdata   = rdata_q;
    assign axil.rresp   = rresp_q;
    assign cfg_wr_pulse = pulse_q;

    assign aw_hs = axil.awvalid && axil.awready;
    assign w_hs  = axil.wvalid && axil.wready;
    assign ar_hs = axil.arvalid && axil.arready;

    // A write commits on the edge where the later of AW/W completes, using held or live values.
    assign commit   = (aw_hold || aw_hs) && (w_hold || w_hs);
    assign w_k      = aw_hold ? aw_k_q : axil.awaddr[ADDR_WIDTH-1:2];
    assign cm_data  = w_hold ? w_data_q : axil.wdata;
    assign cm_strb  = w_hold ? w_strb_q : axil.wstrb;
    assign w_region = decode(w_k);

    assign r_k      = axil.araddr[ADDR_WIDTH-1:2];
    assign r_region = decode(r_k);
    assign rd_ok    = ar_hs && (r_region != REGION_NONE);

    assign addr_lsb_unused = ^{axil.awaddr[1:0], axil.araddr[1:0]};

    for (genvar i = 0; i < N_RW; i++) begin : g_cfg_out
        assign cfg_regs[32*i +: 32] = regs[i];
    end

    always_comb begin
        rd_word = '0;
        case (r_region)
            REGION_RW: begin
                for (int i = 0; i < N_RW; i++) begin
                    if (r_k == KW'(i)) rd_word = regs[i];
                end
            end
            REGION_RO: begin
                for (int j = 0; j < N_RO; j++) begin
                    if (r_k == KW'(N_RW + j)) rd_word = status_in[32*j +: 32];
                end
            end
            REGION_WR_CNT: rd_word = wr_cnt;
            REGION_RD_CNT: rd_word = rd_cnt;
            default:       rd_word = '0;
        endcase
    end

    // A clear of RD_CNT lands first so a same-cycle read accept leaves it at 1.
    always_comb begin
        rd_cnt_next = (commit && w_region == REGION_RD_CNT) ? 32'd0 : rd_cnt;
        if (rd_ok) rd_cnt_next = rd_cnt_next + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en <= 1'b0;
            aw_hold  <= 1'b0;
            aw_k_q   <= '0;
            w_hold   <= 1'b0;
            w_data_q <= '0;
            w_strb_q <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            pulse_q  <= '0;
            for (int i = 0; i < N_RW; i++) regs[i] <= CFG_RESET_VAL;
        end else begin
            ready_en <= 1'b1;
            pulse_q  <= '0;
            rd_cnt   <= rd_cnt_next;
            if (aw_hs) begin
                aw_hold <= 1'b1;
                aw_k_q  <= axil.awaddr[ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
                w_hold   <= 1'b1;
                w_data_q <= axil.wdata;
                w_strb_q <= axil.wstrb;
            end
            if (commit) begin
                aw_hold  <= 1'b0;
                w_hold   <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q  <= (w_region == REGION_RO || w_region == REGION_NONE) ? RESP_SLVERR : RESP_OKAY;
                if (w_region == REGION_RW) begin
                    wr_cnt <= wr_cnt + 32'd1;
                    for (int i = 0; i < N_RW; i++) begin
                        if (w_k == KW'(i)) begin
                            regs[i]    <= merge(regs[i], cm_data, cm_strb);
                            pulse_q[i] <= 1'b1;
                        end
                    end
                end else if (w_region == REGION_WR_CNT) begin
                    wr_cnt <= '0;
                end
            end else if (bvalid_q && axil.bready) begin
                bvalid_q <= 1'b0;
            end
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_word;
                rresp_q  <= (r_region == REGION_NONE) ? RESP_SLVERR : RESP_OKAY;
            end else if (rvalid_q && axil.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rr_cfg_axil_regfile.sv
// Scoreboard bench for rr_cfg_axil_regfile: a register/counter model pushes expected
// B and R responses when stimulus is issued, and a monitor pops and compares them.
module tb_rr_cfg_axil_regfile;
    localparam int          ADDR_WIDTH    = 32;
    localparam int          N_RW          = 8;
    localparam int          N_RO          = 8;
    localparam int          CW            = N_RW * 32;
    localparam logic [31:0] CFG_RESET_VAL = 32'h0;
    localparam logic [31:0] A_STATUS0     = 32'h20;
    localparam logic [31:0] A_WR_CNT      = 32'h40;
    localparam logic [31:0] A_RD_CNT      = 32'h44;
    localparam logic [31:0] A_UNMAPPED    = 32'h48;

    typedef logic [CW-1:0] cw_t;

    typedef struct packed {
        logic [1:0]      resp;
        logic [N_RW-1:0] pulse;
        logic [CW-1:0]   regs;
    } b_exp_t;

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
    } r_exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [CW-1:0]        cfg_regs;
    logic [N_RW-1:0]      cfg_wr_pulse;
    logic [N_RO*32-1:0]   status_in;

    int checks = 0;
    int errors = 0;

    b_exp_t      b_q[$];
    r_exp_t      r_q[$];
    logic [31:0] m_regs [N_RW];
    logic [31:0] m_wr;
    logic [31:0] m_rd;
    logic        b_prev = 1'b0;

    always #5 clk = ~clk;

    rr_cfg_axil_regfile_if #(.ADDR_WIDTH(ADDR_WIDTH)) axil ();

    rr_cfg_axil_regfile #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .N_RW          (N_RW),
        .N_RO          (N_RO),
        .CFG_RESET_VAL (CFG_RESET_VAL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .axil         (axil.slave),
        .cfg_regs     (cfg_regs),
        .cfg_wr_pulse (cfg_wr_pulse),
        .status_in    (status_in)
    );

    task automatic checkOutput(input string tag, input cw_t got, input cw_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic cw_t packRegs();
        cw_t v;
        for (int i = 0; i < N_RW; i++) v[32*i +: 32] = m_regs[i];
        return v;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < N_RW; i++) m_regs[i] = CFG_RESET_VAL;
        m_wr = '0;
        m_rd = '0;
        b_q.delete();
        r_q.delete();
    endtask

    task automatic modelWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int k = int'(a >> 2);
        b_exp_t e;
        e.resp  = 2'b00;
        e.pulse = '0;
        if (k < N_RW) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) m_regs[k][8*b +: 8] = d[8*b +: 8];
            end
            e.pulse[k] = 1'b1;
            m_wr = m_wr + 32'd1;
        end else if (k == N_RW + N_RO) begin
            m_wr = '0;
        end else if (k == N_RW + N_RO + 1) begin
            m_rd = '0;
        end else begin
            e.resp = 2'b10;
        end
        e.regs = packRegs();
        b_q.push_back(e);
    endtask

    task automatic modelRead(input logic [31:0] a);
        int k = int'(a >> 2);
        r_exp_t e;
        e.resp = 2'b00;
        e.data = '0;
        if (k < N_RW)                     e.data = m_regs[k];
        else if (k < N_RW + N_RO)         e.data = status_in[32*(k-N_RW) +: 32];
        else if (k == N_RW + N_RO)        e.data = m_wr;
        else if (k == N_RW + N_RO + 1)    e.data = m_rd;
        else                              e.resp = 2'b10;
        if (e.resp == 2'b00) m_rd = m_rd + 32'd1;
        r_q.push_back(e);
    endtask

    // Channel drivers start just after a rising edge and return just after their handshake edge.
    task automatic driveAw(input logic [31:0] a, input int dly);
        int n = 0;
        if (dly > 0) begin
            repeat (dly) @(posedge clk);
            #1;
        end
        axil.awaddr  = a;
        axil.awvalid = 1'b1;
        @(negedge clk);
        while (!axil.awready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("aw_handshake", cw_t'(axil.awready), cw_t'(1));
        @(posedge clk);
        #1;
        axil.awvalid = 1'b0;
    endtask

    task automatic driveW(input logic [31:0] d, input logic [3:0] s, input int dly);
        int n = 0;
        if (dly > 0) begin
            repeat (dly) @(posedge clk);
            #1;
        end
        axil.wdata  = d;
        axil.wstrb  = s;
        axil.wvalid = 1'b1;
        @(negedge clk);
        while (!axil.wready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("w_handshake", cw_t'(axil.wready), cw_t'(1));
        @(posedge clk);
        #1;
        axil.wvalid = 1'b0;
    endtask

    task automatic driveAr(input logic [31:0] a, input int dly);
        int n = 0;
        if (dly > 0) begin
            repeat (dly) @(posedge clk);
            #1;
        end
        axil.araddr  = a;
        axil.arvalid = 1'b1;
        @(negedge clk);
        while (!axil.arready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ar_handshake", cw_t'(axil.arready), cw_t'(1));
        @(posedge clk);
        #1;
        axil.arvalid = 1'b0;
    endtask

    task automatic driveWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                              input int aw_dly, input int w_dly);
        fork
            driveAw(a, aw_dly);
            driveW(d, s, w_dly);
        join
    endtask

    task automatic applyStimulus(input bit is_wr, input logic [31:0] a,
                                 input logic [31:0] d, input logic [3:0] s);
        if (is_wr) begin
            modelWrite(a, d, s);
            driveWrite(a, d, s, 0, 0);
        end else begin
            modelRead(a);
            driveAr(a, 0);
        end
    endtask

    task automatic waitResp();
        int n = 0;
        while ((b_q.size() != 0 || r_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("resp_drain", cw_t'(b_q.size() + r_q.size()), cw_t'(0));
        @(posedge clk);
        #1;
    endtask

    // Response monitor: pops the scoreboard on every B/R handshake, checks strobes on B rise.
    always @(negedge clk) begin
        b_exp_t be;
        r_exp_t re;
        if (!rst) begin
            if (axil.bvalid && !b_prev) begin
                if (b_q.size() == 0) begin
                    checkOutput("b_unexpected", cw_t'(axil.bvalid), cw_t'(0));
                end else begin
                    checkOutput("b_pulse", cw_t'(cfg_wr_pulse), cw_t'(b_q[0].pulse));
                    checkOutput("b_regs", cfg_regs, b_q[0].regs);
                end
            end else begin
                checkOutput("pulse_idle", cw_t'(cfg_wr_pulse), cw_t'(0));
            end
            if (axil.bvalid && axil.bready && b_q.size() > 0) begin
                be = b_q.pop_front();
                checkOutput("bresp", cw_t'(axil.bresp), cw_t'(be.resp));
            end
            if (axil.rvalid && axil.rready) begin
                if (r_q.size() == 0) begin
                    checkOutput("r_unexpected", cw_t'(axil.rvalid), cw_t'(0));
                end else begin
                    re = r_q.pop_front();
                    checkOutput("rresp", cw_t'(axil.rresp), cw_t'(re.resp));
                    checkOutput("rdata", cw_t'(axil.rdata), cw_t'(re.data));
                end
            end
        end
        b_prev <= axil.bvalid;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst          = 1'b1;
        axil.awaddr  = '0;
        axil.awvalid = 1'b0;
        axil.wdata   = '0;
        axil.wstrb   = '0;
        axil.wvalid  = 1'b0;
        axil.bready  = 1'b1;
        axil.araddr  = '0;
        axil.arvalid = 1'b0;
        axil.rready  = 1'b1;
        for (int j = 0; j < N_RO; j++) status_in[32*j +: 32] = 32'h5000_0000 + 32'(j * 32'h111);
        modelReset();

        // Reset state, then readies rise on the first edge after release
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_awready", cw_t'(axil.awready), cw_t'(0));
        checkOutput("rst_wready", cw_t'(axil.wready), cw_t'(0));
        checkOutput("rst_arready", cw_t'(axil.arready), cw_t'(0));
        checkOutput("rst_bvalid", cw_t'(axil.bvalid), cw_t'(0));
        checkOutput("rst_rvalid", cw_t'(axil.rvalid), cw_t'(0));
        checkOutput("rst_rdata", cw_t'(axil.rdata), cw_t'(0));
        checkOutput("rst_cfg_regs", cfg_regs, packRegs());
        rst = 1'b0;
        #1;
        checkOutput("release_awready", cw_t'(axil.awready), cw_t'(0));
        @(posedge clk);
        #1;
        checkOutput("ready_aw", cw_t'(axil.awready), cw_t'(1));
        checkOutput("ready_w", cw_t'(axil.wready), cw_t'(1));
        checkOutput("ready_ar", cw_t'(axil.arready), cw_t'(1));

        // Read reg0 with one-cycle latency, then RD_CNT
        modelRead(32'h0);
        driveAr(32'h0, 0);
        @(negedge clk);
        checkOutput("r_latency", cw_t'(axil.rvalid), cw_t'(1));
        waitResp();
        applyStimulus(1'b0, A_RD_CNT, 32'h0, 4'h0);
        waitResp();

        // Byte-merged write with AW and W together
        modelWrite(32'h4, 32'hA5A5_1234, 4'b0101);
        driveWrite(32'h4, 32'hA5A5_1234, 4'b0101, 0, 0);
        @(negedge clk);
        checkOutput("b_latency", cw_t'(axil.bvalid), cw_t'(1));
        checkOutput("reg1_merge", cw_t'(cfg_regs[63:32]), cw_t'(32'h00A5_0034));
        waitResp();
        applyStimulus(1'b1, 32'h8, 32'hFFFF_FFFF, 4'b0000);
        waitResp();
        applyStimulus(1'b1, 32'h1C, 32'hDEAD_BEEF, 4'b1111);
        waitResp();
        applyStimulus(1'b1, 32'h1, 32'h7700_0000, 4'b1000);
        waitResp();
        for (int i = 0; i < N_RW; i++) begin
            applyStimulus(1'b0, 32'(i * 4), 32'h0, 4'h0);
            waitResp();
        end

        // W first, AW three cycles later, B held off by bready
        applyStimulus(1'b1, A_WR_CNT, 32'h1234_5678, 4'b0000);
        waitResp();
        axil.bready = 1'b0;
        modelWrite(32'hC, 32'h1234_5678, 4'b1111);
        driveWrite(32'hC, 32'h1234_5678, 4'b1111, 3, 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("bhold_bvalid", cw_t'(axil.bvalid), cw_t'(1));
            checkOutput("bhold_awready", cw_t'(axil.awready), cw_t'(0));
            checkOutput("bhold_wready", cw_t'(axil.wready), cw_t'(0));
        end
        axil.bready = 1'b1;
        waitResp();
        applyStimulus(1'b0, A_WR_CNT, 32'h0, 4'h0);
        waitResp();

        // Status and unmapped accesses, and status sampling at the AR edge
        applyStimulus(1'b1, A_STATUS0, 32'hFFFF_FFFF, 4'b1111);
        waitResp();
        applyStimulus(1'b1, A_UNMAPPED, 32'hFFFF_FFFF, 4'b1111);
        waitResp();
        applyStimulus(1'b0, A_UNMAPPED, 32'h0, 4'h0);
        waitResp();
        applyStimulus(1'b0, A_STATUS0 + 32'hC, 32'h0, 4'h0);
        waitResp();
        status_in[32*3 +: 32] = 32'hCAFE_F00D;
        applyStimulus(1'b0, A_STATUS0 + 32'hC, 32'h0, 4'h0);
        waitResp();

        // RD_CNT wrap from all-ones
        @(negedge clk);
        force dut.rd_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.rd_cnt;
        m_rd = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0);
        waitResp();
        applyStimulus(1'b0, A_RD_CNT, 32'h0, 4'h0);
        waitResp();

        // RD_CNT clear in the same cycle as an OKAY read accept
        modelWrite(A_RD_CNT, 32'h0, 4'h0);
        modelRead(32'h0);
        fork
            driveWrite(A_RD_CNT, 32'h0, 4'h0, 0, 0);
            driveAr(32'h0, 0);
        join
        waitResp();
        applyStimulus(1'b0, A_RD_CNT, 32'h0, 4'h0);
        waitResp();

        // Read of a register in its own commit cycle sees the old value
        modelRead(32'h4);
        modelWrite(32'h4, 32'h1111_2222, 4'b1111);
        fork
            driveWrite(32'h4, 32'h1111_2222, 4'b1111, 0, 0);
            driveAr(32'h4, 0);
        join
        waitResp();

        // Reset with W held and R pending
        axil.rready = 1'b0;
        driveAr(32'h10, 0);
        driveW(32'h5555_5555, 4'b1111, 0);
        @(negedge clk);
        checkOutput("pre_rst_rvalid", cw_t'(axil.rvalid), cw_t'(1));
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("mid_rst_bvalid", cw_t'(axil.bvalid), cw_t'(0));
        checkOutput("mid_rst_rvalid", cw_t'(axil.rvalid), cw_t'(0));
        checkOutput("mid_rst_cfg_regs", cfg_regs, packRegs());
        @(negedge clk);
        rst = 1'b0;
        axil.rready = 1'b1;
        @(posedge clk);
        #1;
        modelWrite(32'h8, 32'h0000_0077, 4'b1111);
        driveAw(32'h8, 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("aw_only_no_b", cw_t'(axil.bvalid), cw_t'(0));
        end
        @(posedge clk);
        #1;
        driveW(32'h0000_0077, 4'b1111, 0);
        waitResp();
        applyStimulus(1'b0, 32'h4, 32'h0, 4'h0);
        waitResp();
        applyStimulus(1'b0, A_WR_CNT, 32'h0, 4'h0);
        waitResp();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
